// File: rtl/vlc_mem_pkg.sv
// Shared memory helpers for the VLC receive buffers: default geometry and
// the wrapping pointer increment used by the FIFO pointers.
package vlc_mem_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 7;
  localparam int RAM_SIZE_DEF   = 128;
  localparam int CNT_WIDTH      = ADDR_WIDTH_DEF + 1;

  // Wraps at size-1 so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned size);
    return (ptr == size - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered synchronous read port.
// Written as a plain array with clocked read so it maps onto block RAM.
module ram_sdp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ram_fifo_sync.sv
// First-word-fall-through FIFO over ram_sdp. The RAM read register is the
// prefetch slot, backed by a skid register. Optional i_flush via FIFO_FLUSH_EN.
module ram_fifo_sync
  import vlc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RAM_SIZE   = RAM_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FIFO_FLUSH_EN
  input  logic                  i_flush,
`endif
  input  logic                  i_w_valid,
  output logic                  o_w_ready,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  output logic                  o_r_valid,
  input  logic                  i_r_ready,
  output logic [DATA_WIDTH-1:0] o_r_data,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, staged, ram_words;
  logic                  full_q, full_d, empty_q, empty_d, w_ready_q, w_ready_d;
  logic                  ram_vld_q, ram_vld_d, skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d, ram_dout;
  logic                  clr, wr_en, rd_en, deliver;

`ifdef FIFO_FLUSH_EN
  assign clr = rst | i_flush;
`else
  assign clr = rst;
`endif

  ram_sdp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (RAM_SIZE)
  ) u_ram (
    .clk_i    (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(i_w_data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(ram_dout)
  );

  always_comb begin
    wr_en      = i_w_valid & w_ready_q;
    o_r_valid  = ram_vld_q | skid_vld_q;
    deliver    = o_r_valid & i_r_ready;
    staged     = CW'(ram_vld_q) + CW'(skid_vld_q);
    // count_q only includes words written at earlier edges, so these are safe to read.
    ram_words  = count_q - staged;
    rd_en      = (ram_words != '0) && !(skid_vld_q && !deliver);

    wr_ptr_d   = wr_en ? ADDR_WIDTH'(ptr_inc(32'(wr_ptr_q), RAM_SIZE)) : wr_ptr_q;
    rd_ptr_d   = rd_en ? ADDR_WIDTH'(ptr_inc(32'(rd_ptr_q), RAM_SIZE)) : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !deliver)      count_d = count_q + CW'(1);
    else if (!wr_en && deliver) count_d = count_q - CW'(1);

    // A new read overwrites the RAM register, so an undelivered word there moves to skid.
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (rd_en && ram_vld_q && (skid_vld_q || !deliver)) begin
      skid_d     = ram_dout;
      skid_vld_d = 1'b1;
    end else if (deliver && skid_vld_q) begin
      skid_vld_d = 1'b0;
    end

    ram_vld_d = ram_vld_q;
    if (rd_en)                        ram_vld_d = 1'b1;
    else if (deliver && !skid_vld_q)  ram_vld_d = 1'b0;

    full_d    = (count_d == CW'(RAM_SIZE));
    empty_d   = (count_d == '0);
    w_ready_d = !full_d;

    if (skid_vld_q)     o_r_data = skid_q;
    else if (ram_vld_q) o_r_data = ram_dout;
    else                o_r_data = '0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      w_ready_q  <= 1'b1;
      ram_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      w_ready_q  <= w_ready_d;
      ram_vld_q  <= ram_vld_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

  assign o_w_ready = w_ready_q;
  assign o_count   = count_q;
  assign o_full    = full_q;
  assign o_empty   = empty_q;

endmodule
